// File: rtl/mem_access_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mem_seq_pkg
// Shared definitions for the memory access sequencer and its arbiter.
//   seq_state_t : sequencer state encoding (3 bits)
//   REQ_CPU     : requester index of the CPU control unit
//   REQ_LDR     : requester index of the program loader / debug port
// ---------------------------------------------------------------------------
package mem_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_RWAIT = 3'd3,
        S_WWAIT = 3'd4,
        S_DONE  = 3'd5
    } seq_state_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_LDR = 1;

endpackage

// File: rtl/mem_access_sequencer_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. When both requesters are active, the one that
// did not win the previous arbitration is granted.
//   i_CLK     : clock
//   i_RST_N   : asynchronous active-low reset
//   i_Req     : request bits, one per requester
//   i_Advance : a grant is being taken this cycle, update the last winner
//   o_Grant   : one-hot grant (combinational from i_Req and the pointer)
// ---------------------------------------------------------------------------
module rr_arbiter2
    import mem_seq_pkg::*;
(
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic [1:0] i_Req,
    input  logic       i_Advance,
    output logic [1:0] o_Grant
);

    // 1 means requester 1 won last, so requester 0 is favoured next.
    logic r_LastWinner;

    always_comb begin
        o_Grant = 2'b00;
        if (i_Req[REQ_CPU] && i_Req[REQ_LDR]) begin
            o_Grant[REQ_CPU] = r_LastWinner;
            o_Grant[REQ_LDR] = ~r_LastWinner;
        end else begin
            o_Grant = i_Req;
        end
    end

    // Reset value favours requester 0 on the first contended grant.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_LastWinner <= 1'b1;
        end else if (i_Advance) begin
            r_LastWinner <= o_Grant[REQ_LDR];
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer
// Owns the control inputs of memory_control on behalf of two requesters
// (CPU control unit and program loader). Each access runs as an address
// phase, an optional write-data phase and a wait-for-ready phase with a
// timeout, then reports completion with a one-cycle o_Done pulse.
//   i_CLK, i_RST_N         : clock, asynchronous active-low reset
//   i_Req, i_WE            : per-requester request level and write enable
//   i_Addr0/1, i_WData0/1  : per-requester address and write data
//   i_MDR_Bus, i_Ready_Bit : MDR contents and ready flag from memory_control
//   o_LD_MAR, o_LD_MDR, o_RW, o_MIO_EN : memory_control controls
//   o_Bus_Drive, o_Bus_Drive_En        : value and enable for the CPU bus mux
//   o_Grant, o_Done, o_Err, o_RData    : per-access owner and completion
// ---------------------------------------------------------------------------
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        i_CLK,
    input  logic        i_RST_N,
    input  logic [1:0]  i_Req,
    input  logic [1:0]  i_WE,
    input  logic [15:0] i_Addr0,
    input  logic [15:0] i_Addr1,
    input  logic [15:0] i_WData0,
    input  logic [15:0] i_WData1,
    input  logic [15:0] i_MDR_Bus,
    input  logic        i_Ready_Bit,
    output logic        o_LD_MAR,
    output logic        o_LD_MDR,
    output logic        o_RW,
    output logic        o_MIO_EN,
    output logic [15:0] o_Bus_Drive,
    output logic        o_Bus_Drive_En,
    output logic [1:0]  o_Grant,
    output logic [1:0]  o_Done,
    output logic        o_Err,
    output logic [15:0] o_RData
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t        r_State;
    logic [1:0]        r_Grant;
    logic              r_WE;
    logic [15:0]       r_Addr;
    logic [15:0]       r_WData;
    logic [CNT_W-1:0]  r_Cnt;
    logic              r_Err;
    logic              r_LD_MAR;
    logic              r_LD_MDR;
    logic              r_RW;
    logic              r_MIO_EN;
    logic [1:0]        r_Done;

    logic [1:0]        w_ArbGrant;
    logic              w_Advance;
    logic              w_SelLdr;
    logic              w_SelWE;
    logic [15:0]       w_SelAddr;
    logic [15:0]       w_SelWData;

    // Arbitration only matters in IDLE; the pointer moves once per grant.
    assign w_Advance = (r_State == S_IDLE) && (|i_Req);

    rr_arbiter2 u_arb (
        .i_CLK     (i_CLK),
        .i_RST_N   (i_RST_N),
        .i_Req     (i_Req),
        .i_Advance (w_Advance),
        .o_Grant   (w_ArbGrant)
    );

    assign w_SelLdr   = w_ArbGrant[REQ_LDR];
    assign w_SelWE    = w_SelLdr ? i_WE[REQ_LDR] : i_WE[REQ_CPU];
    assign w_SelAddr  = w_SelLdr ? i_Addr1 : i_Addr0;
    assign w_SelWData = w_SelLdr ? i_WData1 : i_WData0;

    // Control strobes are registered for the state being entered, so each
    // is high exactly while the FSM sits in the state that needs it.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_State  <= S_IDLE;
            r_Grant  <= 2'b00;
            r_WE     <= 1'b0;
            r_Addr   <= 16'h0000;
            r_WData  <= 16'h0000;
            r_Cnt    <= '0;
            r_Err    <= 1'b0;
            r_LD_MAR <= 1'b0;
            r_LD_MDR <= 1'b0;
            r_RW     <= 1'b0;
            r_MIO_EN <= 1'b0;
            r_Done   <= 2'b00;
        end else begin
            r_LD_MAR <= 1'b0;
            r_LD_MDR <= 1'b0;
            r_RW     <= 1'b0;
            r_MIO_EN <= 1'b0;
            r_Done   <= 2'b00;
            case (r_State)
                S_IDLE: begin
                    if (|i_Req) begin
                        r_Grant  <= w_ArbGrant;
                        r_WE     <= w_SelWE;
                        r_Addr   <= w_SelAddr;
                        r_WData  <= w_SelWData;
                        r_Cnt    <= '0;
                        r_Err    <= 1'b0;
                        r_LD_MAR <= 1'b1;
                        r_State  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_LD_MDR <= 1'b1;
                    if (r_WE) begin
                        r_State <= S_WDATA;
                    end else begin
                        r_MIO_EN <= 1'b1;
                        r_State  <= S_RWAIT;
                    end
                end
                S_WDATA: begin
                    r_MIO_EN <= 1'b1;
                    r_RW     <= 1'b1;
                    r_State  <= S_WWAIT;
                end
                S_RWAIT, S_WWAIT: begin
                    // Ready wins over the timeout when both land on the same edge.
                    if (i_Ready_Bit || (r_Cnt == LAST_WAIT)) begin
                        r_Done  <= r_Grant;
                        r_Err   <= ~i_Ready_Bit;
                        r_State <= S_DONE;
                    end else begin
                        r_Cnt    <= r_Cnt + CNT_W'(1);
                        r_MIO_EN <= 1'b1;
                        r_RW     <= (r_State == S_WWAIT);
                        r_LD_MDR <= (r_State == S_RWAIT);
                    end
                end
                S_DONE: begin
                    r_Grant <= 2'b00;
                    r_Cnt   <= '0;
                    r_Err   <= 1'b0;
                    r_State <= S_IDLE;
                end
                default: begin
                    r_State <= S_IDLE;
                end
            endcase
        end
    end

    // Bus data comes straight from the latched request, selected by state.
    assign o_Bus_Drive_En = (r_State == S_ADDR) || (r_State == S_WDATA);
    assign o_Bus_Drive    = (r_State == S_ADDR)  ? r_Addr  :
                            (r_State == S_WDATA) ? r_WData : 16'h0000;

    // The MDR is frozen in DONE (LD_MDR low), so it can be passed through.
    assign o_RData = ((r_State == S_DONE) && !r_WE) ? i_MDR_Bus : 16'h0000;

    assign o_LD_MAR = r_LD_MAR;
    assign o_LD_MDR = r_LD_MDR;
    assign o_RW     = r_RW;
    assign o_MIO_EN = r_MIO_EN;
    assign o_Grant  = r_Grant;
    assign o_Done   = r_Done;
    assign o_Err    = r_Err;

endmodule
